einstein_kbd_matrix: RTL and testbench

- Keyboard responder for the Einstein core. Turns a raw PS/2 scancode byte stream into the Einstein 8x8 key matrix.
- Answers the row strobes the PSG drives on port A (kb_row) with column data on port B (kb_col).
- Also supplies the shift/ctrl/graph status lines and the kb_down level that the top-level keyboard interrupt logic edge-detects.
- Sits between the PS/2 byte receiver and the PSG/status-port glue in the system top.

---
 rtl/einstein_kbd_pkg.sv | 51 +++++
 rtl/einstein_keymap.sv | 90 +++++++++
 rtl/einstein_kbd_matrix.sv | 193 +++++++++++++++++++
 tb/tb_einstein_kbd_matrix.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/einstein_kbd_pkg.sv
// Shared types and constants for the Einstein keyboard responder.
// Covers the prefix decoder states, the scancode constants and the keymap entry format.
package einstein_kbd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } kbd_state_t;

   localparam logic [7:0] PFX_EXT     = 8'hE0;
   localparam logic [7:0] PFX_BRK     = 8'hF0;
   localparam logic [7:0] PFX_PAUSE   = 8'hE1;
   localparam logic [7:0] CODE_BAT    = 8'hAA;
   localparam logic [7:0] CODE_ERR_FF = 8'hFF;
   localparam logic [7:0] CODE_ERR_00 = 8'h00;

   // The right ctrl and right alt keys share a code with the left key and differ only by E0
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;

   typedef struct packed {
      logic       hit;
      logic [2:0] row;
      logic [2:0] col;
   } keymap_entry_t;

   typedef struct packed {
      logic lshift;
      logic rshift;
      logic lctrl;
      logic rctrl;
      logic lalt;
      logic ralt;
   } mod_flags_t;

   localparam keymap_entry_t KM_MISS = '{hit: 1'b0, row: 3'd0, col: 3'd0};

   function automatic keymap_entry_t km(input logic [2:0] row, input logic [2:0] col);
      keymap_entry_t e;
      e.hit = 1'b1;
      e.row = row;
      e.col = col;
      return e;
   endfunction

endpackage

// File: rtl/einstein_keymap.sv
// Combinational ROM from a set-2 scancode, qualified by the E0 prefix, to the Einstein key matrix.
// The lookup misses (hit=0) for any code that has no key on the Einstein keyboard.
module einstein_keymap
   import einstein_kbd_pkg::*;
(
   input  logic          ext,
   input  logic [7:0]    code,
   output keymap_entry_t entry
);

   always_comb begin
      entry = KM_MISS;
      case ({ext, code})
         9'h016: entry = km(3'd0, 3'd0);
         9'h01E: entry = km(3'd0, 3'd1);
         9'h026: entry = km(3'd0, 3'd2);
         9'h025: entry = km(3'd0, 3'd3);
         9'h02E: entry = km(3'd0, 3'd4);
         9'h029: entry = km(3'd0, 3'd5);
         9'h00D: entry = km(3'd0, 3'd6);
         9'h076: entry = km(3'd0, 3'd7);

         9'h015: entry = km(3'd1, 3'd0);
         9'h01D: entry = km(3'd1, 3'd1);
         9'h024: entry = km(3'd1, 3'd2);
         9'h02D: entry = km(3'd1, 3'd3);
         9'h02C: entry = km(3'd1, 3'd4);
         9'h036: entry = km(3'd1, 3'd5);
         9'h03D: entry = km(3'd1, 3'd6);
         9'h03E: entry = km(3'd1, 3'd7);

         9'h01A: entry = km(3'd2, 3'd0);
         9'h01C: entry = km(3'd2, 3'd1);
         9'h01B: entry = km(3'd2, 3'd2);
         9'h023: entry = km(3'd2, 3'd3);
         9'h02B: entry = km(3'd2, 3'd4);
         9'h034: entry = km(3'd2, 3'd5);
         9'h046: entry = km(3'd2, 3'd6);
         9'h045: entry = km(3'd2, 3'd7);

         9'h022: entry = km(3'd3, 3'd0);
         9'h021: entry = km(3'd3, 3'd1);
         9'h02A: entry = km(3'd3, 3'd2);
         9'h032: entry = km(3'd3, 3'd3);
         9'h033: entry = km(3'd3, 3'd4);
         9'h035: entry = km(3'd3, 3'd5);
         9'h03C: entry = km(3'd3, 3'd6);
         9'h043: entry = km(3'd3, 3'd7);

         9'h031: entry = km(3'd4, 3'd0);
         9'h03A: entry = km(3'd4, 3'd1);
         9'h03B: entry = km(3'd4, 3'd2);
         9'h042: entry = km(3'd4, 3'd3);
         9'h044: entry = km(3'd4, 3'd4);
         9'h04D: entry = km(3'd4, 3'd5);
         9'h04B: entry = km(3'd4, 3'd6);
         9'h04C: entry = km(3'd4, 3'd7);

         9'h041: entry = km(3'd5, 3'd0);
         9'h049: entry = km(3'd5, 3'd1);
         9'h04A: entry = km(3'd5, 3'd2);
         9'h04E: entry = km(3'd5, 3'd3);
         9'h055: entry = km(3'd5, 3'd4);
         9'h054: entry = km(3'd5, 3'd5);
         9'h05B: entry = km(3'd5, 3'd6);
         9'h052: entry = km(3'd5, 3'd7);

         9'h05A: entry = km(3'd6, 3'd0);
         9'h066: entry = km(3'd6, 3'd1);
         9'h05D: entry = km(3'd6, 3'd2);
         9'h00E: entry = km(3'd6, 3'd3);
         9'h005: entry = km(3'd6, 3'd4);
         9'h006: entry = km(3'd6, 3'd5);
         9'h004: entry = km(3'd6, 3'd6);
         9'h00C: entry = km(3'd6, 3'd7);

         // Cursor and editing cluster lives on the E0 page
         9'h16B: entry = km(3'd7, 3'd0);
         9'h174: entry = km(3'd7, 3'd1);
         9'h172: entry = km(3'd7, 3'd2);
         9'h175: entry = km(3'd7, 3'd3);
         9'h170: entry = km(3'd7, 3'd4);
         9'h171: entry = km(3'd7, 3'd5);
         9'h16C: entry = km(3'd7, 3'd6);
         9'h15A: entry = km(3'd7, 3'd7);
         default: entry = KM_MISS;
      endcase
   end

endmodule

// File: rtl/einstein_kbd_matrix.sv
// PS/2 set-2 byte stream to Einstein 8x8 key matrix, answering PSG row strobes with column data.
// Also drives the shift/ctrl/graph status lines and the kb_down level for the interrupt logic.
module einstein_kbd_matrix
   import einstein_kbd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1600000,
   parameter int unsigned PAUSE_LEN   = 7
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_valid,
   input  logic [7:0] ps2_data,
   input  logic [7:0] kb_row,
   output logic [7:0] kb_col,
   output logic       kb_shift,
   output logic       kb_ctrl,
   output logic       kb_graph,
   output logic       kb_down,
   output logic       code_err
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int SW = $clog2(PAUSE_LEN + 1);

   kbd_state_t    state_q, state_d;
   logic [SW-1:0] skip_q, skip_d;
   logic [TW-1:0] timeout_q, timeout_d;
   logic [63:0]   key_q, key_d;
   mod_flags_t    mods_q, mods_d;
   logic [7:0]    kb_col_q, kb_col_d;
   logic          kb_shift_q, kb_shift_d;
   logic          kb_ctrl_q, kb_ctrl_d;
   logic          kb_graph_q, kb_graph_d;
   logic          kb_down_q, kb_down_d;
   logic          code_err_q, code_err_d;

   logic          ev_valid;
   logic          ev_make;
   logic          ev_ext;
   logic          clear_all;
   keymap_entry_t entry;

   einstein_keymap u_keymap (
      .ext   (ev_ext),
      .code  (ps2_data),
      .entry (entry)
   );

   // Prefix decoder: turns the byte stream into single make/break events on {ext, code}
   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      timeout_d = timeout_q;
      ev_valid  = 1'b0;
      ev_make   = 1'b0;
      ev_ext    = 1'b0;
      clear_all = 1'b0;
      if (ps2_valid) begin
         timeout_d = '0;
         unique case (state_q)
            ST_IDLE: begin
               case (ps2_data)
                  PFX_EXT:   state_d = ST_EXT;
                  PFX_BRK:   state_d = ST_BRK;
                  PFX_PAUSE: begin
                     state_d = ST_PAUSE;
                     skip_d  = SW'(PAUSE_LEN);
                  end
                  CODE_BAT, CODE_ERR_FF, CODE_ERR_00: clear_all = 1'b1;
                  default: begin
                     ev_valid = 1'b1;
                     ev_make  = 1'b1;
                  end
               endcase
            end
            ST_EXT: begin
               if (ps2_data == PFX_BRK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  ev_valid = 1'b1;
                  ev_make  = 1'b1;
                  ev_ext   = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_BRK: begin
               ev_valid = 1'b1;
               state_d  = ST_IDLE;
            end
            ST_EXT_BRK: begin
               ev_valid = 1'b1;
               ev_ext   = 1'b1;
               state_d  = ST_IDLE;
            end
            ST_PAUSE: begin
               if (skip_q <= SW'(1)) begin
                  skip_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  skip_d = skip_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         // A stalled prefix is dropped without touching the matrix
         if (timeout_q == TW'(TIMEOUT_CYC - 1)) begin
            timeout_d = '0;
            skip_d    = '0;
            state_d   = ST_IDLE;
         end else begin
            timeout_d = timeout_q + 1'b1;
         end
      end
   end

   // Modifiers are steered to flags; everything else goes through the keymap
   always_comb begin
      key_d      = key_q;
      mods_d     = mods_q;
      code_err_d = 1'b0;
      if (clear_all) begin
         key_d  = '0;
         mods_d = '0;
      end else if (ev_valid) begin
         case ({ev_ext, ps2_data})
            {1'b0, SC_LSHIFT}: mods_d.lshift = ev_make;
            {1'b0, SC_RSHIFT}: mods_d.rshift = ev_make;
            {1'b0, SC_CTRL}:   mods_d.lctrl  = ev_make;
            {1'b1, SC_CTRL}:   mods_d.rctrl  = ev_make;
            {1'b0, SC_ALT}:    mods_d.lalt   = ev_make;
            {1'b1, SC_ALT}:    mods_d.ralt   = ev_make;
            default: begin
               if (entry.hit) begin
                  key_d[{entry.row, entry.col}] = ev_make;
               end else begin
                  code_err_d = 1'b1;
               end
            end
         endcase
      end
   end

   // Several selected rows combine as a wired-AND on the column lines
   always_comb begin
      kb_col_d = 8'hFF;
      for (int r = 0; r < 8; r++) begin
         if (!kb_row[r]) begin
            kb_col_d = kb_col_d & ~key_q[r*8 +: 8];
         end
      end
      kb_shift_d = ~(mods_q.lshift | mods_q.rshift);
      kb_ctrl_d  = ~(mods_q.lctrl | mods_q.rctrl);
      kb_graph_d = ~(mods_q.lalt | mods_q.ralt);
      kb_down_d  = |key_q;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         skip_q     <= '0;
         timeout_q  <= '0;
         key_q      <= '0;
         mods_q     <= '0;
         kb_col_q   <= 8'hFF;
         kb_shift_q <= 1'b1;
         kb_ctrl_q  <= 1'b1;
         kb_graph_q <= 1'b1;
         kb_down_q  <= 1'b0;
         code_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         skip_q     <= skip_d;
         timeout_q  <= timeout_d;
         key_q      <= key_d;
         mods_q     <= mods_d;
         kb_col_q   <= kb_col_d;
         kb_shift_q <= kb_shift_d;
         kb_ctrl_q  <= kb_ctrl_d;
         kb_graph_q <= kb_graph_d;
         kb_down_q  <= kb_down_d;
         code_err_q <= code_err_d;
      end
   end

   assign kb_col   = kb_col_q;
   assign kb_shift = kb_shift_q;
   assign kb_ctrl  = kb_ctrl_q;
   assign kb_graph = kb_graph_q;
   assign kb_down  = kb_down_q;
   assign code_err = code_err_q;

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Bench for einstein_kbd_matrix: a byte-level model of the keyboard is compared every cycle,
// and directed sequences pin known column, status and error values.
module tb_einstein_kbd_matrix;

   localparam int TIMEOUT   = 200;
   localparam int PAUSE_LEN = 7;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       ps2_valid;
   logic [7:0] ps2_data;
   logic [7:0] kb_row;
   logic [7:0] kb_col;
   logic       kb_shift;
   logic       kb_ctrl;
   logic       kb_graph;
   logic       kb_down;
   logic       code_err;

   int checks = 0;
   int errors = 0;
   logic compare_en = 1'b0;

   einstein_kbd_matrix #(
      .TIMEOUT_CYC (TIMEOUT),
      .PAUSE_LEN   (PAUSE_LEN)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_valid (ps2_valid),
      .ps2_data  (ps2_data),
      .kb_row    (kb_row),
      .kb_col    (kb_col),
      .kb_shift  (kb_shift),
      .kb_ctrl   (kb_ctrl),
      .kb_graph  (kb_graph),
      .kb_down   (kb_down),
      .code_err  (code_err)
   );

   always #5 clk_sys = ~clk_sys;

   // Keys the bench uses: {ext, code} -> row*8 + col
   int km_tab [logic [8:0]];
   initial begin
      km_tab[9'h01C] = 2*8 + 1;
      km_tab[9'h029] = 0*8 + 5;
      km_tab[9'h05A] = 6*8 + 0;
      km_tab[9'h175] = 7*8 + 3;
   end

   // mods bits: 0 lshift, 1 rshift, 2 lctrl, 3 rctrl, 4 lalt, 5 ralt
   typedef struct packed {
      logic [63:0] key;
      logic [5:0]  mods;
      logic        ext;
      logic        brk;
      logic [3:0]  skip;
      logic [31:0] idle;
      logic        err;
   } model_t;

   model_t     m = '0;
   logic [7:0] exp_col   = 8'hFF;
   logic       exp_down  = 1'b0;
   logic       exp_shift = 1'b1;
   logic       exp_ctrl  = 1'b1;
   logic       exp_graph = 1'b1;

   function automatic model_t apply_key(model_t n, logic ext, logic make, logic [7:0] b);
      model_t r = n;
      if (!ext && b == 8'h12) r.mods[0] = make;
      else if (!ext && b == 8'h59) r.mods[1] = make;
      else if (b == 8'h14) r.mods[ext ? 3 : 2] = make;
      else if (b == 8'h11) r.mods[ext ? 5 : 4] = make;
      else if (km_tab.exists({ext, b})) r.key[km_tab[{ext, b}]] = make;
      else r.err = 1'b1;
      return r;
   endfunction

   function automatic model_t step(model_t cur, logic valid, logic [7:0] b);
      model_t n = cur;
      n.err = 1'b0;
      if (valid) begin
         n.idle = 0;
         if (cur.skip != 0) begin
            n.skip = cur.skip - 1;
         end else if (cur.brk) begin
            n = apply_key(n, cur.ext, 1'b0, b);
            n.ext = 1'b0;
            n.brk = 1'b0;
         end else if (cur.ext) begin
            if (b == 8'hF0) n.brk = 1'b1;
            else begin
               n = apply_key(n, 1'b1, 1'b1, b);
               n.ext = 1'b0;
            end
         end else begin
            case (b)
               8'hE0: n.ext = 1'b1;
               8'hF0: n.brk = 1'b1;
               8'hE1: n.skip = 4'(PAUSE_LEN);
               8'hAA, 8'hFF, 8'h00: begin
                  n.key  = '0;
                  n.mods = '0;
               end
               default: n = apply_key(n, 1'b0, 1'b1, b);
            endcase
         end
      end else if (cur.ext || cur.brk || cur.skip != 0) begin
         n.idle = cur.idle + 1;
         if (n.idle == TIMEOUT) begin
            n.ext  = 1'b0;
            n.brk  = 1'b0;
            n.skip = '0;
            n.idle = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] col_of(logic [63:0] key, logic [7:0] row);
      logic [7:0] c = 8'hFF;
      for (int r = 0; r < 8; r++) begin
         if (!row[r]) c = c & ~key[r*8 +: 8];
      end
      return c;
   endfunction

   always @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         m         <= '0;
         exp_col   <= 8'hFF;
         exp_down  <= 1'b0;
         exp_shift <= 1'b1;
         exp_ctrl  <= 1'b1;
         exp_graph <= 1'b1;
      end else begin
         exp_col   <= col_of(m.key, kb_row);
         exp_down  <= |m.key;
         exp_shift <= ~(m.mods[0] | m.mods[1]);
         exp_ctrl  <= ~(m.mods[2] | m.mods[3]);
         exp_graph <= ~(m.mods[4] | m.mods[5]);
         m         <= step(m, ps2_valid, ps2_data);
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk_sys) begin
      if (compare_en) begin
         checkOutput("cyc_kb_col",   kb_col,          exp_col);
         checkOutput("cyc_kb_down",  {7'd0, kb_down},  {7'd0, exp_down});
         checkOutput("cyc_kb_shift", {7'd0, kb_shift}, {7'd0, exp_shift});
         checkOutput("cyc_kb_ctrl",  {7'd0, kb_ctrl},  {7'd0, exp_ctrl});
         checkOutput("cyc_kb_graph", {7'd0, kb_graph}, {7'd0, exp_graph});
         checkOutput("cyc_code_err", {7'd0, code_err}, {7'd0, m.err});
      end
   end

   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk_sys);
      #1;
      ps2_valid = 1'b1;
      ps2_data  = b;
      @(posedge clk_sys);
      #1;
      ps2_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_col"},   kb_col,           8'hFF);
      checkOutput({tag, "_down"},  {7'd0, kb_down},  8'h00);
      checkOutput({tag, "_shift"}, {7'd0, kb_shift}, 8'h01);
      checkOutput({tag, "_ctrl"},  {7'd0, kb_ctrl},  8'h01);
      checkOutput({tag, "_graph"}, {7'd0, kb_graph}, 8'h01);
      checkOutput({tag, "_err"},   {7'd0, code_err}, 8'h00);
   endtask

   initial begin
      reset     = 1'b1;
      ps2_valid = 1'b0;
      ps2_data  = 8'h00;
      kb_row    = 8'hFF;
      #1 compare_en = 1'b1;
      settle();
      checkReset("rst");
      @(negedge clk_sys);
      reset = 1'b0;

      // Single key make and break
      kb_row = 8'hFB;
      applyStimulus(8'h1C);
      settle();
      checkOutput("a_make_col", kb_col, 8'hFD);
      checkOutput("a_make_down", {7'd0, kb_down}, 8'h01);
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);
      settle();
      checkOutput("a_break_col", kb_col, 8'hFF);
      checkOutput("a_break_down", {7'd0, kb_down}, 8'h00);

      // Two rows selected at once
      applyStimulus(8'h1C);
      applyStimulus(8'h29);
      applyStimulus(8'h1C);
      kb_row = 8'hFA;
      settle();
      checkOutput("two_rows_col", kb_col, 8'hDD);
      kb_row = 8'hFF;
      settle();
      checkOutput("no_rows_col", kb_col, 8'hFF);
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);
      applyStimulus(8'hF0);
      applyStimulus(8'h29);
      applyStimulus(8'hF0);
      applyStimulus(8'h29);

      // Extended key, its break, and an unmapped code
      kb_row = 8'h7F;
      applyStimulus(8'hE0);
      applyStimulus(8'h75);
      settle();
      checkOutput("up_make_col", kb_col, 8'hF7);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h75);
      settle();
      checkOutput("up_break_col", kb_col, 8'hFF);
      applyStimulus(8'h75);
      @(negedge clk_sys);
      checkOutput("unmapped_err", {7'd0, code_err}, 8'h01);
      @(negedge clk_sys);
      checkOutput("unmapped_err_end", {7'd0, code_err}, 8'h00);
      checkOutput("unmapped_col", kb_col, 8'hFF);

      // Modifiers
      applyStimulus(8'h12);
      applyStimulus(8'h59);
      settle();
      checkOutput("shift_both", {7'd0, kb_shift}, 8'h00);
      applyStimulus(8'hF0);
      applyStimulus(8'h12);
      settle();
      checkOutput("shift_right_only", {7'd0, kb_shift}, 8'h00);
      applyStimulus(8'hF0);
      applyStimulus(8'h59);
      settle();
      checkOutput("shift_none", {7'd0, kb_shift}, 8'h01);
      applyStimulus(8'hE0);
      applyStimulus(8'h14);
      applyStimulus(8'h11);
      settle();
      checkOutput("rctrl", {7'd0, kb_ctrl}, 8'h00);
      checkOutput("lalt", {7'd0, kb_graph}, 8'h00);
      checkOutput("mod_down", {7'd0, kb_down}, 8'h00);
      applyStimulus(8'hF0);
      applyStimulus(8'h11);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h14);
      settle();
      checkOutput("ctrl_released", {7'd0, kb_ctrl}, 8'h01);

      // Stalled E0 is abandoned, so the next byte is a plain make
      kb_row = 8'hFB;
      applyStimulus(8'hE0);
      repeat (TIMEOUT + 10) @(posedge clk_sys);
      #1;
      applyStimulus(8'h1C);
      settle();
      checkOutput("timeout_plain_make", kb_col, 8'hFD);
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);

      // E0 held just under the timeout still qualifies the next byte
      kb_row = 8'h7F;
      applyStimulus(8'hE0);
      repeat (TIMEOUT - 5) @(posedge clk_sys);
      #1;
      applyStimulus(8'h75);
      settle();
      checkOutput("no_timeout_ext_make", kb_col, 8'hF7);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h75);

      // Pause sequence swallows seven bytes, then decoding resumes
      applyStimulus(8'h5A);
      applyStimulus(8'hE1);
      applyStimulus(8'h14);
      applyStimulus(8'h77);
      applyStimulus(8'hE1);
      applyStimulus(8'hF0);
      applyStimulus(8'h14);
      applyStimulus(8'hF0);
      applyStimulus(8'h77);
      kb_row = 8'hBF;
      settle();
      checkOutput("pause_keeps_return", kb_col, 8'hFE);
      applyStimulus(8'h29);
      kb_row = 8'hFE;
      settle();
      checkOutput("pause_then_space", kb_col, 8'hDF);

      // Reset in the middle of a break, with a strobe during reset
      kb_row = 8'hFB;
      applyStimulus(8'h1C);
      applyStimulus(8'hF0);
      reset = 1'b1;
      @(posedge clk_sys);
      #1;
      ps2_valid = 1'b1;
      ps2_data  = 8'h1C;
      @(posedge clk_sys);
      #1;
      ps2_valid = 1'b0;
      settle();
      checkReset("mid_brk_rst");
      @(negedge clk_sys);
      reset = 1'b0;
      settle();
      checkOutput("post_rst_col", kb_col, 8'hFF);
      applyStimulus(8'h1C);
      settle();
      checkOutput("post_rst_make", kb_col, 8'hFD);

      // BAT code wipes held keys
      applyStimulus(8'h29);
      kb_row = 8'hFA;
      settle();
      checkOutput("pre_bat_col", kb_col, 8'hDD);
      applyStimulus(8'hAA);
      settle();
      checkOutput("bat_col", kb_col, 8'hFF);
      checkOutput("bat_down", {7'd0, kb_down}, 8'h00);

      @(negedge clk_sys);
      compare_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
